prog_flash_bitstream: RTL and testbench

// - Writes a channel-FPGA bitstream into the SPI flash region that the channel-programming sequencer later reads back.
// - Sync image base is 0x0100_0000; async image base is 0x012E_0000 (both in extended-address segment 1).
// - Accepts 32-bit words from the IPbus-side data path and buffers one 256-byte page at a time in the spi_flash_intf WBUF.
// - Drives the same spi_flash_intf command handshake as the other flash sequencers: WREN, EAR, sector erase, page program, status poll.

---
 rtl/prog_flash_bitstream_if.sv | 36 +++
 rtl/prog_flash_bitstream.sv | 235 +++++++++++++++++++++++
 tb/tb_prog_flash_bitstream.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_flash_bitstream_if.sv
// Command/WBUF handshake between a flash sequencer and spi_flash_intf.
// master: store_flash_command, wbuf_address, flash_command,
//         flash_wr_nBits, flash_rd_nBits, send_write_command (out);
//         end_write_command, status_byte (in). slave is the mirror.
interface prog_flash_bitstream_if;
   logic        store_flash_command;
   logic [6:0]  wbuf_address;
   logic [31:0] flash_command;
   logic [11:0] flash_wr_nBits;
   logic [11:0] flash_rd_nBits;
   logic        send_write_command;
   logic        end_write_command;
   logic [7:0]  status_byte;

   modport master (
      output store_flash_command,
      output wbuf_address,
      output flash_command,
      output flash_wr_nBits,
      output flash_rd_nBits,
      output send_write_command,
      input  end_write_command,
      input  status_byte
   );

   modport slave (
      input  store_flash_command,
      input  wbuf_address,
      input  flash_command,
      input  flash_wr_nBits,
      input  flash_rd_nBits,
      input  send_write_command,
      output end_write_command,
      output status_byte
   );
endinterface

// File: rtl/prog_flash_bitstream.sv
// Writes a channel-FPGA bitstream (sync or async image) into SPI flash,
// one 256-byte page at a time, through the spi_flash_intf WBUF.
// Ports: clk, reset (sync, active-high); async_mode, prog_flash_start,
// n_pages (run setup); data_in/data_valid/data_ready (word stream);
// flash (command/WBUF handshake, master side); flash_in_progress,
// prog_flash_done, prog_flash_error, pages_written, state (status).
// Optional: define PROG_FLASH_TIMEOUT_EN to bound WIP polling by
// POLL_LIMIT RDSRs; on expiry the run is abandoned with EAR restored.
module prog_flash_bitstream #(
   parameter logic [23:0] SYNC_BASE  = 24'h00_0000,
   parameter logic [23:0] ASYNC_BASE = 24'h2E_0000,
   parameter logic [19:0] POLL_LIMIT = 20'hFFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        async_mode,
   input  logic        prog_flash_start,
   input  logic [15:0] n_pages,
   input  logic [31:0] data_in,
   input  logic        data_valid,
   output logic        data_ready,
   output logic        flash_in_progress,
   output logic        prog_flash_done,
   output logic        prog_flash_error,
   output logic [15:0] pages_written,
   output logic [4:0]  state,
   prog_flash_bitstream_if.master flash
);

   typedef enum logic [4:0] {
      S_IDLE     = 5'd0,
      S_WREN     = 5'd1,
      S_EAR1     = 5'd2,
      S_PAGE     = 5'd3,
      S_E_WREN   = 5'd4,
      S_E_SE     = 5'd5,
      S_E_POLL   = 5'd6,
      S_FILL     = 5'd7,
      S_P_WREN   = 5'd8,
      S_P_PP     = 5'd9,
      S_P_POLL   = 5'd10,
      S_END_WREN = 5'd11,
      S_EAR0     = 5'd12,
      S_DONE     = 5'd13
   } st_t;

   st_t         st;
   logic        start_q;
   logic        phase;
   logic [23:0] base_q;
   logic [15:0] n_pages_q;
   logic [15:0] page_idx;
   logic [5:0]  word_idx;
   logic [23:0] addr;
   logic [23:0] start_base;
   logic [24:0] end_addr;
   logic        over;
   logic        wip;
   logic [31:0] cmd_word;
   logic [11:0] cmd_wr;
   logic [11:0] cmd_rd;
`ifdef PROG_FLASH_TIMEOUT_EN
   logic [19:0] poll_cnt;
`endif

   assign state      = st;
   assign wip        = flash.status_byte[0];
   assign addr       = base_q + {page_idx, 8'h00};
   assign start_base = async_mode ? ASYNC_BASE : SYNC_BASE;
   assign end_addr   = {1'b0, start_base} + {1'b0, n_pages, 8'h00};
   assign over       = end_addr > 25'h100_0000;

   always_comb begin
      cmd_word = 32'h0600_0000;
      cmd_wr   = 12'd7;
      cmd_rd   = 12'd0;
      case (st)
         S_EAR1: begin
            cmd_word = 32'hC501_0000;
            cmd_wr   = 12'd15;
         end
         S_EAR0: begin
            cmd_word = 32'hC500_0000;
            cmd_wr   = 12'd15;
         end
         S_E_SE: begin
            cmd_word = {8'hD8, addr};
            cmd_wr   = 12'd31;
         end
         S_P_PP: begin
            cmd_word = {8'h02, addr};
            cmd_wr   = 12'd2079;
         end
         S_E_POLL, S_P_POLL: begin
            cmd_word = 32'h0500_0000;
            cmd_rd   = 12'd7;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st                        <= S_IDLE;
         start_q                   <= 1'b0;
         phase                     <= 1'b0;
         base_q                    <= '0;
         n_pages_q                 <= '0;
         page_idx                  <= '0;
         word_idx                  <= '0;
         data_ready                <= 1'b0;
         flash_in_progress         <= 1'b0;
         prog_flash_done           <= 1'b0;
         prog_flash_error          <= 1'b0;
         pages_written             <= '0;
         flash.store_flash_command <= 1'b0;
         flash.wbuf_address        <= '0;
         flash.flash_command       <= '0;
         flash.flash_wr_nBits      <= '0;
         flash.flash_rd_nBits      <= '0;
         flash.send_write_command  <= 1'b0;
`ifdef PROG_FLASH_TIMEOUT_EN
         poll_cnt                  <= '0;
`endif
      end else begin
         start_q                   <= prog_flash_start;
         flash.store_flash_command <= 1'b0;
         case (st)
            S_IDLE: begin
               if (prog_flash_start && !start_q) begin
                  n_pages_q         <= n_pages;
                  base_q            <= start_base;
                  page_idx          <= '0;
                  word_idx          <= '0;
                  pages_written     <= '0;
                  phase             <= 1'b0;
                  flash_in_progress <= 1'b1;
                  prog_flash_error  <= over;
                  st                <= over ? S_END_WREN : S_WREN;
               end
            end
            S_PAGE: begin
               if (page_idx == n_pages_q) begin
                  st <= S_END_WREN;
               end else if (page_idx == 16'd0 || addr[15:0] == 16'd0) begin
                  st <= S_E_WREN;
               end else begin
                  st         <= S_FILL;
                  data_ready <= 1'b1;
                  word_idx   <= '0;
               end
            end
            S_FILL: begin
               if (data_valid) begin
                  flash.store_flash_command <= 1'b1;
                  flash.wbuf_address        <= {1'b0, word_idx} + 7'd1;
                  flash.flash_command       <= data_in;
                  word_idx                  <= word_idx + 6'd1;
                  if (word_idx == 6'd63) begin
                     data_ready <= 1'b0;
                     st         <= S_P_WREN;
                  end
               end
            end
            S_DONE: begin
               if (!prog_flash_start) begin
                  prog_flash_done <= 1'b0;
                  st              <= S_IDLE;
               end
            end
            default: begin
               if (!phase) begin
                  flash.store_flash_command <= 1'b1;
                  flash.wbuf_address        <= 7'd0;
                  flash.flash_command       <= cmd_word;
                  flash.flash_wr_nBits      <= cmd_wr;
                  flash.flash_rd_nBits      <= cmd_rd;
                  phase                     <= 1'b1;
               end else if (!flash.send_write_command) begin
                  flash.send_write_command <= 1'b1;
               end else if (flash.end_write_command) begin
                  flash.send_write_command <= 1'b0;
                  phase                    <= 1'b0;
                  case (st)
                     S_WREN:     st <= S_EAR1;
                     S_EAR1:     st <= S_PAGE;
                     S_E_WREN:   st <= S_E_SE;
                     S_P_WREN:   st <= S_P_PP;
                     S_END_WREN: st <= S_EAR0;
                     S_E_SE: begin
                        st <= S_E_POLL;
`ifdef PROG_FLASH_TIMEOUT_EN
                        poll_cnt <= '0;
`endif
                     end
                     S_P_PP: begin
                        st <= S_P_POLL;
`ifdef PROG_FLASH_TIMEOUT_EN
                        poll_cnt <= '0;
`endif
                     end
                     S_EAR0: begin
                        st                <= S_DONE;
                        prog_flash_done   <= 1'b1;
                        flash_in_progress <= 1'b0;
                     end
                     default: begin
                        if (!wip) begin
                           if (st == S_E_POLL) begin
                              st         <= S_FILL;
                              data_ready <= 1'b1;
                              word_idx   <= '0;
                           end else begin
                              pages_written <= pages_written + 16'd1;
                              page_idx      <= page_idx + 16'd1;
                              st            <= S_PAGE;
                           end
                        end
`ifdef PROG_FLASH_TIMEOUT_EN
                        else if (poll_cnt == POLL_LIMIT - 20'd1) begin
                           prog_flash_error <= 1'b1;
                           st               <= S_END_WREN;
                        end else begin
                           poll_cnt <= poll_cnt + 20'd1;
                        end
`endif
                     end
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_flash_bitstream.sv
// Testbench for prog_flash_bitstream: flash responder, command/data
// scoreboard and directed runs.
module tb_prog_flash_bitstream;

   typedef struct packed {
      logic [1:0]  kind;
      logic        pre;
      logic [6:0]  a;
      logic [31:0] v;
      logic [11:0] wr;
      logic [11:0] rd;
   } ev_t;

   localparam logic [31:0] C_WREN = 32'h0600_0000;
   localparam logic [31:0] C_EAR1 = 32'hC501_0000;
   localparam logic [31:0] C_EAR0 = 32'hC500_0000;
   localparam logic [31:0] C_RDSR = 32'h0500_0000;
`ifdef PROG_FLASH_TIMEOUT_EN
   localparam int WIPN = 2;
   localparam logic [19:0] PL = 20'd4;
`else
   localparam int WIPN = 5;
   localparam logic [19:0] PL = 20'hFFFFF;
`endif

   logic        clk;
   logic        reset;
   logic        async_mode;
   logic        prog_flash_start;
   logic [15:0] n_pages;
   logic [31:0] data_in;
   logic        data_valid;
   logic        data_ready;
   logic        flash_in_progress;
   logic        prog_flash_done;
   logic        prog_flash_error;
   logic [15:0] pages_written;
   logic [4:0]  state;

   prog_flash_bitstream_if bus ();

   prog_flash_bitstream #(.POLL_LIMIT(PL)) dut (
      .clk               (clk),
      .reset             (reset),
      .async_mode        (async_mode),
      .prog_flash_start  (prog_flash_start),
      .n_pages           (n_pages),
      .data_in           (data_in),
      .data_valid        (data_valid),
      .data_ready        (data_ready),
      .flash_in_progress (flash_in_progress),
      .prog_flash_done   (prog_flash_done),
      .prog_flash_error  (prog_flash_error),
      .pages_written     (pages_written),
      .state             (state),
      .flash             (bus)
   );

   int          n_assert = 0;
   int          n_fail   = 0;
   ev_t         exp_q[$];
   int          wip_n    = 0;
   int          wip_left = 0;
   logic [31:0] wbuf0    = '0;
   bit          prev_st  = 0;
   bit          busy     = 0;
   int          lat      = 0;
   bit          abort    = 0;
   int          consumed = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      repeat (150000) @(posedge clk);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic check_ev(input ev_t o);
      ev_t e;
      e = '0;
      e.kind = 2'd3;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      n_assert++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL event: observed k%0d p%0d a%0d v%h w%0d r%0d required k%0d p%0d a%0d v%h w%0d r%0d",
                o.kind, o.pre, o.a, o.v, o.wr, o.rd,
                e.kind, e.pre, e.a, e.v, e.wr, e.rd);
      end
   endtask

   task automatic push_cmd(input logic [31:0] c, input int wr, input int rd);
      ev_t e;
      e      = '0;
      e.pre  = 1'b1;
      e.v    = c;
      e.wr   = 12'(wr);
      e.rd   = 12'(rd);
      exp_q.push_back(e);
   endtask

   task automatic push_dat(input int a, input logic [31:0] v);
      ev_t e;
      e      = '0;
      e.kind = 2'd1;
      e.a    = 7'(a);
      e.v    = v;
      exp_q.push_back(e);
   endtask

   task automatic exp_run(input logic [23:0] base, input int n, input int wn,
                          input int seed, input bit rerr);
      logic [23:0] a;
      if (!rerr) begin
         push_cmd(C_WREN, 7, 0);
         push_cmd(C_EAR1, 15, 0);
         for (int p = 0; p < n; p++) begin
            a = base + 24'(p * 256);
            if (p == 0 || a[15:0] == 16'h0000) begin
               push_cmd(C_WREN, 7, 0);
               push_cmd({8'hD8, a}, 31, 0);
               for (int r = 0; r <= wn; r++) push_cmd(C_RDSR, 7, 7);
            end
            for (int w = 0; w < 64; w++) push_dat(1 + w, 32'(seed + p * 64 + w));
            push_cmd(C_WREN, 7, 0);
            push_cmd({8'h02, a}, 2079, 0);
            for (int r = 0; r <= wn; r++) push_cmd(C_RDSR, 7, 7);
         end
      end
      push_cmd(C_WREN, 7, 0);
      push_cmd(C_EAR0, 15, 0);
   endtask

   initial begin
      ev_t o;
      logic [7:0] op;
      bus.end_write_command = 1'b0;
      bus.status_byte       = 8'h00;
      forever begin
         @(negedge clk);
         bus.end_write_command = 1'b0;
         if (!bus.send_write_command) busy = 0;
         if (bus.send_write_command && !busy) begin
            busy = 1;
            lat  = 2;
            o      = '0;
            o.pre  = prev_st;
            o.v    = wbuf0;
            o.wr   = bus.flash_wr_nBits;
            o.rd   = bus.flash_rd_nBits;
            check_ev(o);
            op = wbuf0[31:24];
            if (op == 8'hD8 || op == 8'h02) begin
               wip_left = wip_n;
            end else if (op == 8'h05) begin
               bus.status_byte = (wip_left > 0) ? 8'h83 : 8'h82;
               if (wip_left > 0) wip_left--;
            end
         end else if (busy && lat > 0) begin
            lat--;
            if (lat == 0) bus.end_write_command = 1'b1;
         end
         prev_st = bus.store_flash_command && bus.wbuf_address == 7'd0;
         if (bus.store_flash_command) begin
            if (bus.wbuf_address == 7'd0) begin
               wbuf0 = bus.flash_command;
            end else begin
               o      = '0;
               o.kind = 2'd1;
               o.a    = bus.wbuf_address;
               o.v    = bus.flash_command;
               check_ev(o);
            end
         end
      end
   end

   task automatic feed(input int nw, input int seed, input bit gap,
                       input int lim);
      int k = 0;
      int cyc = 0;
      while (k < nw && cyc < lim && !abort) begin
         @(negedge clk);
         data_in    = 32'(seed + k);
         data_valid = !gap || (cyc % 3 == 0);
         if (data_valid && data_ready) k++;
         cyc++;
      end
      @(negedge clk);
      data_valid = 1'b0;
      consumed   = k;
   endtask

   task automatic wait_done(input int lim);
      int c = 0;
      while (prog_flash_done !== 1'b1 && c < lim) begin
         @(negedge clk);
         c++;
      end
      chk("done_in_time", 32'(c < lim), 32'd1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, 32'({data_ready, flash_in_progress,
                              bus.store_flash_command, bus.send_write_command,
                              prog_flash_done, prog_flash_error, state,
                              bus.wbuf_address}), 32'd0);
      chk({tag, "_cmd"}, bus.flash_command, 32'd0);
      chk({tag, "_nbits"}, {8'd0, bus.flash_wr_nBits, bus.flash_rd_nBits}, 32'd0);
      chk({tag, "_pages"}, 32'(pages_written), 32'd0);
   endtask

   task automatic do_run(input bit am, input int n, input int wn,
                         input int seed, input bit gap, input bit rerr);
      int lim;
      int nw;
      nw  = rerr ? 0 : n * 64;
      lim = rerr ? 500 : n * ((gap ? 200 : 70) + 60 + 12 * wn) + 500;
      exp_run(am ? 24'h2E_0000 : 24'h00_0000, n, wn, seed, rerr);
      wip_n      = wn;
      wip_left   = 0;
      async_mode = am;
      n_pages    = 16'(n);
      @(negedge clk);
      prog_flash_start = 1'b1;
      fork
         feed(nw, seed, gap, lim);
         wait_done(lim);
      join
      chk("done", 32'(prog_flash_done), 32'd1);
      chk("error", 32'(prog_flash_error), 32'(rerr));
      chk("pages_written", 32'(pages_written), rerr ? 32'd0 : 32'(n));
      chk("in_progress", 32'(flash_in_progress), 32'd0);
      chk("consumed", 32'(consumed), 32'(nw));
      repeat (8) @(negedge clk);
      chk("held_done", 32'(prog_flash_done), 32'd1);
      chk("no_extra", 32'(exp_q.size()), 32'd0);
      prog_flash_start = 1'b0;
      repeat (2) @(negedge clk);
      chk("back_idle", 32'(state), 32'd0);
      chk("done_clear", 32'(prog_flash_done), 32'd0);
   endtask

   initial begin
      int c;
      reset            = 1'b1;
      async_mode       = 1'b0;
      prog_flash_start = 1'b0;
      n_pages          = '0;
      data_in          = '0;
      data_valid       = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      reset = 1'b0;
      repeat (2) @(negedge clk);

      do_run(1'b0, 1, 0, 0, 1'b0, 1'b0);
      do_run(1'b0, 2, WIPN, 32'h1000, 1'b1, 1'b0);
      do_run(1'b1, 16'hD201, 0, 0, 1'b0, 1'b1);
      do_run(1'b0, 0, 0, 0, 1'b0, 1'b0);

      push_cmd(C_WREN, 7, 0);
      push_cmd(C_EAR1, 15, 0);
      push_cmd(C_WREN, 7, 0);
      push_cmd({8'hD8, 24'h2E_0000}, 31, 0);
      wip_n      = 0;
      async_mode = 1'b1;
      n_pages    = 16'hD200;
      @(negedge clk);
      prog_flash_start = 1'b1;
      c = 0;
      while (exp_q.size() != 0 && c < 200) begin
         @(negedge clk);
         c++;
      end
      chk("edge_reach_se", 32'(c < 200), 32'd1);
      chk("edge_no_error", 32'(prog_flash_error), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk_zero("edge_reset");
      reset            = 1'b0;
      prog_flash_start = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);

      exp_run(24'h00_0000, 3, 0, 32'h5000, 1'b0);
      wip_n      = 0;
      async_mode = 1'b0;
      n_pages    = 16'd3;
      abort      = 0;
      @(negedge clk);
      prog_flash_start = 1'b1;
      fork
         feed(192, 32'h5000, 1'b0, 3000);
         begin
            c = 0;
            while (!(pages_written == 16'd1 && data_ready) && c < 2000) begin
               @(negedge clk);
               c++;
            end
            chk("reach_fill2", 32'(c < 2000), 32'd1);
            repeat (10) @(negedge clk);
            reset = 1'b1;
            abort = 1;
            @(negedge clk);
            chk_zero("fill_reset");
            reset            = 1'b0;
            prog_flash_start = 1'b0;
         end
      join
      exp_q.delete();
      abort = 0;
      repeat (3) @(negedge clk);

      do_run(1'b0, 1, 0, 32'h7000, 1'b0, 1'b0);
      do_run(1'b1, 257, 0, 32'hA000_0000, 1'b0, 1'b0);

`ifdef PROG_FLASH_TIMEOUT_EN
      push_cmd(C_WREN, 7, 0);
      push_cmd(C_EAR1, 15, 0);
      push_cmd(C_WREN, 7, 0);
      push_cmd({8'hD8, 24'h00_0000}, 31, 0);
      for (int r = 0; r < 4; r++) push_cmd(C_RDSR, 7, 7);
      push_cmd(C_WREN, 7, 0);
      push_cmd(C_EAR0, 15, 0);
      wip_n      = 1000000;
      async_mode = 1'b0;
      n_pages    = 16'd1;
      @(negedge clk);
      prog_flash_start = 1'b1;
      wait_done(500);
      chk("to_error", 32'(prog_flash_error), 32'd1);
      chk("to_pages", 32'(pages_written), 32'd0);
      chk("to_no_extra", 32'(exp_q.size()), 32'd0);
      prog_flash_start = 1'b0;
      repeat (3) @(negedge clk);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
